// File: rtl/sdr_link_token_rx_pkg.sv
// sdr_link_token_rx_pkg: shared link defaults and derived counter widths
package sdr_link_token_rx_pkg;

  localparam int unsigned LINK_WIDTH    = 32;
  localparam int unsigned LG_FIFO_DEPTH = 3;
  localparam int unsigned LG_CREDIT_DEC = 0;

  function automatic int unsigned fifo_cnt_w(input int unsigned lg_depth);
    return lg_depth + 1;
  endfunction

  function automatic int unsigned credit_cnt_w(input int unsigned lg_dec);
    return lg_dec + 1;
  endfunction

  localparam int unsigned FIFO_CNT_W   = fifo_cnt_w(LG_FIFO_DEPTH);
  localparam int unsigned CREDIT_CNT_W = credit_cnt_w(LG_CREDIT_DEC);

endpackage

// File: rtl/sdr_link_rx_fifo.sv
// sdr_link_rx_fifo: 1R1W receive buffer with wrapping pointers and occupancy count
module sdr_link_rx_fifo
  import sdr_link_token_rx_pkg::*;
#(
  parameter int unsigned width_p    = LINK_WIDTH,
  parameter int unsigned lg_depth_p = LG_FIFO_DEPTH
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned CNT_W = fifo_cnt_w(lg_depth_p);
  localparam int unsigned DEPTH = 1 << lg_depth_p;

  if (lg_depth_p < 1) begin : g_bad_depth
    $error("sdr_link_rx_fifo: lg_depth_p must be >= 1");
  end

  logic [width_p-1:0]    mem_q [DEPTH];
  logic [lg_depth_p-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // pointers wrap naturally at the power-of-two depth; count tracks net enq-deq
  always_comb begin
    wr_d  = wr_q + lg_depth_p'(enq_i);
    rd_d  = rd_q + lg_depth_p'(deq_i);
    cnt_d = cnt_q + CNT_W'(enq_i) - CNT_W'(deq_i);
  end

  // pointer and count state, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset; stale entries are never visible while empty
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = cnt_q == CNT_W'(DEPTH);
  assign empty_o = cnt_q == '0;

endmodule

// File: rtl/sdr_link_token_rx.sv
// sdr_link_token_rx: SDR link receive buffer issuing decimated credit tokens
module sdr_link_token_rx
  import sdr_link_token_rx_pkg::*;
#(
  parameter int unsigned width_p                         = LINK_WIDTH,
  parameter int unsigned lg_fifo_depth_p                 = LG_FIFO_DEPTH,
  parameter int unsigned lg_credit_to_token_decimation_p = LG_CREDIT_DEC
) (
  input  logic                                     core_clk_i,
  input  logic                                     core_reset_n_i,
  input  logic                                     link_v_i,
  input  logic [width_p-1:0]                       link_data_i,
  output logic                                     link_token_o,
  output logic                                     core_v_o,
  output logic [width_p-1:0]                       core_data_o,
  input  logic                                     core_yumi_i,
  output logic                                     overflow_o,
  output logic [lg_credit_to_token_decimation_p:0] credit_count_o
);

  localparam int unsigned CW = credit_cnt_w(lg_credit_to_token_decimation_p);
  localparam logic [CW-1:0] CMAX = CW'((1 << lg_credit_to_token_decimation_p) - 1);

  if (lg_credit_to_token_decimation_p > lg_fifo_depth_p) begin : g_bad_dec
    $error("sdr_link_token_rx: token decimation exceeds FIFO depth");
  end

  logic          full, empty, enq, deq;
  logic          token_q, token_d, ovf_q, ovf_d;
  logic [CW-1:0] credit_q, credit_d;

  sdr_link_rx_fifo #(
    .width_p   (width_p),
    .lg_depth_p(lg_fifo_depth_p)
  ) u_fifo (
    .clk_i    (core_clk_i),
    .reset_n_i(core_reset_n_i),
    .enq_i    (enq),
    .data_i   (link_data_i),
    .deq_i    (deq),
    .data_o   (core_data_o),
    .full_o   (full),
    .empty_o  (empty)
  );

  // a simultaneous dequeue frees the slot, so a full FIFO still accepts the word
  always_comb begin
    deq      = core_yumi_i & ~empty;
    enq      = link_v_i & (~full | deq);
    ovf_d    = ovf_q | (link_v_i & full & ~deq);
    token_d  = deq && credit_q == CMAX;
    credit_d = !deq ? credit_q : token_d ? '0 : credit_q + CW'(1);
  end

  // token, credit and sticky overflow registers
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      token_q  <= 1'b0;
      ovf_q    <= 1'b0;
      credit_q <= '0;
    end else begin
      token_q  <= token_d;
      ovf_q    <= ovf_d;
      credit_q <= credit_d;
    end
  end

  // yumi without a valid head is ignored by the datapath; flag it in simulation
  always_ff @(posedge core_clk_i) begin
    if (core_reset_n_i) assert (!core_yumi_i || !empty);
  end

  assign core_v_o       = ~empty;
  assign link_token_o   = token_q;
  assign overflow_o     = ovf_q;
  assign credit_count_o = credit_q;

endmodule

// File: tb/tb_sdr_link_token_rx.sv
// tb_sdr_link_token_rx: directed scoreboard bench for the SDR link receiver
module tb_sdr_link_token_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v = 1'b0, y = 1'b0;
  logic [31:0] d = '0;
  logic        tok_a, cv_a, ovf_a, tok_b, cv_b, ovf_b;
  logic [31:0] cd_a, cd_b;
  logic [0:0]  cc_a;
  logic [2:0]  cc_b;
  logic        vc = 1'b0, yc = 1'b0;
  logic [31:0] dc = '0;
  logic        tok_c, cv_c, ovf_c;
  logic [31:0] cd_c;
  logic [0:0]  cc_c;

  int errors = 0, checks = 0;
  int ntok_b = 0, ntok_c = 0;
  logic [31:0] q[$], qc[$];
  int mcnt = 0, mc = 0, credb = 0;
  logic ovf_m = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tok_b) ntok_b++;
    if (tok_c) ntok_c++;
  end

  sdr_link_token_rx #(.width_p(32), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(0)) u_a (
    .core_clk_i(clk), .core_reset_n_i(rst_n), .link_v_i(v), .link_data_i(d),
    .link_token_o(tok_a), .core_v_o(cv_a), .core_data_o(cd_a), .core_yumi_i(y),
    .overflow_o(ovf_a), .credit_count_o(cc_a));

  sdr_link_token_rx #(.width_p(32), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(2)) u_b (
    .core_clk_i(clk), .core_reset_n_i(rst_n), .link_v_i(v), .link_data_i(d),
    .link_token_o(tok_b), .core_v_o(cv_b), .core_data_o(cd_b), .core_yumi_i(y),
    .overflow_o(ovf_b), .credit_count_o(cc_b));

  sdr_link_token_rx #(.width_p(32), .lg_fifo_depth_p(1), .lg_credit_to_token_decimation_p(0)) u_c (
    .core_clk_i(clk), .core_reset_n_i(rst_n), .link_v_i(vc), .link_data_i(dc),
    .link_token_o(tok_c), .core_v_o(cv_c), .core_data_o(cd_c), .core_yumi_i(yc),
    .overflow_o(ovf_c), .credit_count_o(cc_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic vi, input logic [31:0] di, input logic yi);
    logic acc, tb_exp;
    logic [31:0] e;
    v = vi; d = di; y = yi;
    if (yi) begin
      e = q.pop_front();
      chk("head_v_a", cv_a, 1);
      chk("head_a", cd_a, e);
      chk("head_b", cd_b, e);
    end
    acc = vi && (mcnt < 8 || yi);
    if (acc) q.push_back(di);
    mcnt = mcnt + int'(acc) - int'(yi);
    ovf_m = ovf_m | (vi & ~acc);
    if (yi) credb = (credb == 3) ? 0 : credb + 1;
    tb_exp = yi && credb == 0;
    tick();
    chk("token_a", tok_a, yi);
    chk("token_b", tok_b, tb_exp);
    chk("credit_a", cc_a, 0);
    chk("credit_b", cc_b, credb);
    chk("ovf_a", ovf_a, ovf_m);
    chk("ovf_b", ovf_b, ovf_m);
    chk("valid_a", cv_a, mcnt != 0);
    chk("valid_b", cv_b, mcnt != 0);
  endtask

  task automatic cyc_c(input logic vi, input logic [31:0] di, input logic yi);
    logic acc;
    vc = vi; dc = di; yc = yi;
    if (yi) chk("head_c", cd_c, qc.pop_front());
    acc = vi && (mc < 2 || yi);
    if (acc) qc.push_back(di);
    mc = mc + int'(acc) - int'(yi);
    tick();
    chk("token_c", tok_c, yi);
    chk("ovf_c", ovf_c, 0);
    chk("valid_c", cv_c, mc != 0);
  endtask

  task automatic do_reset();
    v = 1'b0; y = 1'b0; vc = 1'b0; yc = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid_a", cv_a, 0);
    chk("rst_token_a", tok_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_credit_b", cc_b, 0);
    chk("rst_valid_b", cv_b, 0);
    chk("rst_valid_c", cv_c, 0);
    #2 rst_n = 1'b1;
    q.delete(); qc.delete();
    mcnt = 0; mc = 0; credb = 0; ovf_m = 1'b0;
    tick();
    chk("post_rst_token_b", tok_b, 0);
  endtask

  initial begin
    int base;
    repeat (2) tick();
    chk("init_valid_a", cv_a, 0);
    chk("init_token_a", tok_a, 0);
    chk("init_ovf_a", ovf_a, 0);
    chk("init_credit_b", cc_b, 0);
    rst_n = 1'b1;
    tick();

    // basic latency
    repeat (3) cycle(0, 0, 0);
    cycle(1, 32'hDEADBEEF, 0);
    chk("lat_data", cd_a, 32'hDEADBEEF);
    cycle(0, 0, 1);
    cycle(0, 0, 0);

    // fill past full, overflow sticks, drain in order
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1, i, 0);
    repeat (2) cycle(0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1);
    chk("ovf_sticky", ovf_a, 1);

    // reset mid-operation with partial credit
    for (int i = 0; i < 5; i++) cycle(1, 32'h50 + i, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1);
    chk("mid_credit_b", cc_b, 3);
    base = ntok_b;
    do_reset();
    repeat (2) cycle(0, 0, 0);
    chk("mid_no_token", ntok_b - base, 0);
    cycle(1, 32'h77, 0);
    chk("mid_data", cd_a, 32'h77);
    cycle(0, 0, 1);

    // full with simultaneous write and yumi
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 32'h10 + i, 0);
    cycle(1, 32'hA5, 1);
    chk("full_rw_ovf", ovf_a, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1);
    chk("full_rw_empty", cv_a, 0);

    // decimation 4 over 10 dequeues
    do_reset();
    base = ntok_b;
    for (int i = 0; i < 10; i++) cycle(1, 32'h200 + i, i > 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    chk("dec_tokens", ntok_b - base, 2);
    chk("dec_credit", cc_b, 2);

    // pointer wrap on a depth-2 FIFO
    do_reset();
    base = ntok_c;
    for (int i = 0; i < 20; i++) cyc_c(1, 32'h100 + i, i > 0);
    cyc_c(0, 0, 1);
    cyc_c(0, 0, 0);
    chk("wrap_tokens", ntok_c - base, 20);
    chk("wrap_credit", cc_c, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
